// File: rtl/uart_stim_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_stim_tx
// Purpose  : FIFO-buffered 8N1/8N2 serial byte source gated by active-low rts
// Revision : 1.0
// ============================================================================
module uart_stim_tx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int DEPTH        = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       rts,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [BW-1:0] c_BIT_LOAD  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_STOP_LOAD = BW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE       = CW'(1);
    localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);

    logic            r_rts_meta;
    logic            r_rts_s;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_sh;
    logic            r_txd;
    logic            r_busy;

    logic            w_push;
    logic            w_pop;
    logic            w_stop_done;
    logic            w_busy_nxt;
    logic [CW-1:0]   w_count_nxt;

    assign in_ready    = (r_count != c_FULL);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = (r_state == S_IDLE) & (r_count != '0) & ~r_rts_s;
    assign w_stop_done = (r_state == S_STOP) & (r_baud == '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // busy looks one state ahead so it lands on the same edge as fifo_count
    assign w_busy_nxt = (w_count_nxt != '0) | w_pop |
                        ((r_state != S_IDLE) & ~w_stop_done);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rts_meta <= 1'b1;
            r_rts_s    <= 1'b1;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_sh       <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_rts_meta <= rts;
            r_rts_s    <= r_rts_meta;
            r_count    <= w_count_nxt;
            r_busy     <= w_busy_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end

            // txd follows the state one edge late, so it falls the edge after the pop
            case (r_state)
                S_START: r_txd <= 1'b0;
                S_DATA:  r_txd <= r_sh[0];
                default: r_txd <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_sh    <= r_mem[r_rptr];
                        r_rptr  <= r_rptr + c_PTR_ONE;
                        r_baud  <= c_BIT_LOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == '0) begin
                        r_baud    <= c_BIT_LOAD;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == '0) begin
                        r_sh      <= {1'b0, r_sh[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_baud  <= c_STOP_LOAD;
                            r_state <= S_STOP;
                        end else begin
                            r_baud <= c_BIT_LOAD;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    if (r_baud == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
            endcase
        end
    end

    assign txd        = r_txd;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_stim_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_stim_tx
// Purpose  : Directed bench for uart_stim_tx (1 and 2 stop-bit instances)
// Revision : 1.0
// ============================================================================
module tb_uart_stim_tx;

    logic       clk;
    logic       reset;
    logic [7:0] in_data,  in_data2;
    logic       in_valid, in_valid2;
    logic       in_ready, in_ready2;
    logic       rts,      rts2;
    logic       txd1,     txd2;
    logic       busy1,    busy2;
    logic [3:0] count1,   count2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    uart_stim_tx #(.CLKS_PER_BIT(4), .DEPTH(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rts(rts), .txd(txd1), .busy(busy1),
        .fifo_count(count1)
    );

    uart_stim_tx #(.CLKS_PER_BIT(4), .DEPTH(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .rts(rts2), .txd(txd2), .busy(busy2),
        .fifo_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the edge where txd fell; returns just after the edge
    // that ends the last stop bit. raise_k >= 0 sets rts high at that cycle.
    task automatic frame_check(input int sel, input logic [7:0] b, input int sb,
                               input int raise_k, input string tag);
        logic exp;
        for (int k = 0; k < (9 + sb) * 4; k++) begin
            if (k / 4 == 0)      exp = 1'b0;
            else if (k / 4 <= 8) exp = b[k/4 - 1];
            else                 exp = 1'b1;
            check($sformatf("%s txd k=%0d", tag, k), (sel == 1) ? txd2 : txd1, exp);
            if (k == raise_k) rts = 1'b1;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rts = 1'b0; rts2 = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; in_data2 = 8'h00; in_valid2 = 1'b0;
        tick(); tick();
        check("reset txd", txd1, 1'b1);
        check("reset busy", busy1, 1'b0);
        check("reset count", count1, 4'd0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset txd2", txd2, 1'b1);
        reset = 1'b0;
        tick(); tick(); tick();

        // 1: single byte 0x55
        in_data = 8'h55; in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("t1 count after push", count1, 4'd1);
        check("t1 busy after push", busy1, 1'b1);
        tick();
        check("t1 txd at pop edge", txd1, 1'b1);
        check("t1 count after pop", count1, 4'd0);
        tick();
        check("t1 busy at start", busy1, 1'b1);
        frame_check(0, 8'h55, 1, -1, "t1");
        check("t1 busy after stop", busy1, 1'b0);
        check("t1 txd after stop", txd1, 1'b1);
        tick();

        // 2: three back-to-back bytes, 41 clk spacing
        in_valid = 1'b1;
        in_data = 8'h41; tick();
        in_data = 8'h42; tick();
        check("t2 count push/pop", count1, 4'd1);
        in_data = 8'h43; tick();
        in_valid = 1'b0;
        check("t2 count f1", count1, 4'd2);
        frame_check(0, 8'h41, 1, -1, "t2 f1");
        check("t2 idle gap", txd1, 1'b1);
        tick();
        check("t2 count f2", count1, 4'd1);
        frame_check(0, 8'h42, 1, -1, "t2 f2");
        tick();
        check("t2 count f3", count1, 4'd0);
        frame_check(0, 8'h43, 1, -1, "t2 f3");
        tick();

        // 3: fill FIFO with rts high, then drain
        rts = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(i);
            tick();
            if (i == 7) check("t3 in_ready at full", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        check("t3 count full", count1, 4'd8);
        check("t3 in_ready", in_ready, 1'b0);
        check("t3 txd held", txd1, 1'b1);
        check("t3 busy", busy1, 1'b1);
        rts = 1'b0;
        tick(); tick(); tick();
        check("t3 txd before start", txd1, 1'b1);
        check("t3 count after first pop", count1, 4'd7);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3 count f%0d", i), count1, 32'(7 - i));
            frame_check(0, 8'(i), 1, -1, $sformatf("t3 f%0d", i));
            tick();
        end
        check("t3 drained count", count1, 4'd0);
        check("t3 drained busy", busy1, 1'b0);

        // 4: rts raised during data bit 3 does not truncate the frame
        in_valid = 1'b1;
        in_data = 8'hA5; tick();
        in_data = 8'h5A; tick();
        in_valid = 1'b0;
        tick();
        frame_check(0, 8'hA5, 1, 17, "t4 f1");
        check("t4 held txd", txd1, 1'b1);
        check("t4 held count", count1, 4'd1);
        check("t4 held busy", busy1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4 hold idle", txd1, 1'b1);
        end
        rts = 1'b0;
        tick(); tick(); tick();
        check("t4 txd before restart", txd1, 1'b1);
        tick();
        frame_check(0, 8'h5A, 1, -1, "t4 f2");
        tick();

        // 5: reset during bit 5 of 0xFF with 3 bytes queued
        in_valid = 1'b1;
        in_data = 8'hFF; tick();
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        check("t5 queued count", count1, 4'd3);
        for (int i = 0; i < 24; i++) tick();
        check("t5 txd in bit5", txd1, 1'b1);
        check("t5 busy in bit5", busy1, 1'b1);
        reset = 1'b1;
        tick();
        check("t5 txd after reset", txd1, 1'b1);
        check("t5 count after reset", count1, 4'd0);
        check("t5 busy after reset", busy1, 1'b0);
        check("t5 in_ready after reset", in_ready, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t5 quiet txd", txd1, 1'b1);
        end
        check("t5 quiet busy", busy1, 1'b0);

        // 6: two stop bits, 45 clk spacing, push coinciding with pop
        in_valid2 = 1'b1;
        in_data2 = 8'h80; tick();
        in_data2 = 8'h01; tick();
        in_valid2 = 1'b0;
        check("t6 count push/pop", count2, 4'd1);
        tick();
        frame_check(1, 8'h80, 2, -1, "t6 f1");
        check("t6 idle gap", txd2, 1'b1);
        tick();
        frame_check(1, 8'h01, 2, -1, "t6 f2");
        tick();
        check("t6 busy end", busy2, 1'b0);
        check("t6 count end", count2, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
